lock_sequencer: RTL and testbench

Cycle-level sequencer that drives the code checker from the keypad and submit inputs. It gathers digits and issues store and compare strobes, and interprets the checker's pass/fail result. It counts failed attempts and enforces a timed lockout. While unlocked, it handles re-programming of the system password. It sits between the user panel and code_checker and supplies the status used for the hex display.

---
 rtl/lock_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_lock_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// Keypad/submit sequencer in front of code_checker: digit gathering, compare strobes,
// fail counting with timed lockout, and password re-programming. Optional: LOCKSEQ_AUTO_RELOCK_EN.
module lock_sequencer #(
    parameter int unsigned PASS_LEN       = 4,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned RESULT_TIMEOUT = 8
`ifdef LOCKSEQ_AUTO_RELOCK_EN
    ,
    parameter int unsigned AUTO_RELOCK_CYCLES = 5000
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       submit,
    input  logic       program_req,
    input  logic       correct_password,
    input  logic       incorrect_password,
    output logic [3:0] bits,
    output logic       input_value,
    output logic       store_value,
    output logic       compare,
    output logic       input_reset,
    output logic       system_reset,
    output logic [2:0] num_inputs,
    output logic [2:0] fail_count,
    output logic       unlocked,
    output logic       locked_out,
    output logic [3:0] state_code
);

    localparam int unsigned CNT_W    = 3;
    localparam int unsigned TMR_BASE = (LOCKOUT_CYCLES > RESULT_TIMEOUT) ? LOCKOUT_CYCLES
                                                                        : RESULT_TIMEOUT;
`ifdef LOCKSEQ_AUTO_RELOCK_EN
    localparam int unsigned TMR_MAX  = (AUTO_RELOCK_CYCLES > TMR_BASE) ? AUTO_RELOCK_CYCLES
                                                                       : TMR_BASE;
`else
    localparam int unsigned TMR_MAX  = TMR_BASE;
`endif
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] PASS_N = CNT_W'(PASS_LEN);
    localparam logic [CNT_W-1:0] FAIL_N = CNT_W'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_WAIT     = 3'd2,
        S_UNLOCKED = 3'd3,
        S_FAIL     = 3'd4,
        S_LOCKOUT  = 3'd5,
        S_PROGRAM  = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic [3:0]         bits_q, bits_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               input_value_q, input_value_d;
    logic               store_value_q, store_value_d;
    logic               compare_q, compare_d;
    logic               input_reset_q, input_reset_d;
    logic               system_reset_q, system_reset_d;
    logic               unlocked_q, locked_out_q;
    logic [3:0]         state_code_q;
    logic               digit_ok;
    logic [CNT_W-1:0]   fail_inc;

    // One shared timer serves result timeout, lockout and (optionally) auto-relock.
    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        fail_d         = fail_q;
        bits_d         = bits_q;
        timer_d        = timer_q;
        input_value_d  = 1'b0;
        store_value_d  = 1'b0;
        compare_d      = 1'b0;
        input_reset_d  = 1'b0;
        system_reset_d = 1'b0;
        digit_ok       = digit_valid && !submit && (num_q < PASS_N);
        fail_inc       = (fail_q < FAIL_N) ? fail_q + CNT_W'(1) : fail_q;

        unique case (state_q)
            S_IDLE: begin
                if (digit_ok) begin
                    bits_d        = digit;
                    num_d         = num_q + CNT_W'(1);
                    input_value_d = 1'b1;
                    state_d       = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (submit) begin
                    if (num_q == PASS_N) begin
                        compare_d = 1'b1;
                        timer_d   = '0;
                        state_d   = S_WAIT;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (digit_ok) begin
                    bits_d        = digit;
                    num_d         = num_q + CNT_W'(1);
                    input_value_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (incorrect_password) begin
                    state_d = S_FAIL;
                end else if (correct_password) begin
                    fail_d  = '0;
                    timer_d = '0;
                    state_d = S_UNLOCKED;
                end else if (timer_q == TMR_W'(RESULT_TIMEOUT - 1)) begin
                    state_d = S_FAIL;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_FAIL: begin
                fail_d = fail_inc;
                if (fail_inc == FAIL_N) begin
                    timer_d = '0;
                    state_d = S_LOCKOUT;
                end else begin
                    input_reset_d = 1'b1;
                    num_d         = '0;
                    state_d       = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                    input_reset_d = 1'b1;
                    fail_d        = '0;
                    num_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_UNLOCKED: begin
                if (submit) begin
                    input_reset_d = 1'b1;
                    num_d         = '0;
                    state_d       = S_IDLE;
                end else if (program_req) begin
                    system_reset_d = 1'b1;
                    num_d          = '0;
                    state_d        = S_PROGRAM;
                end
`ifdef LOCKSEQ_AUTO_RELOCK_EN
                else if (timer_q == TMR_W'(AUTO_RELOCK_CYCLES - 1)) begin
                    input_reset_d = 1'b1;
                    num_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`else
                // Without auto-relock the unlocked state holds until submit or program_req.
`endif
            end
            S_PROGRAM: begin
                if (submit) begin
                    if (num_q == PASS_N) begin
                        input_reset_d = 1'b1;
                        num_d         = '0;
                        state_d       = S_IDLE;
                    end
                end else if (digit_ok) begin
                    bits_d        = digit;
                    num_d         = num_q + CNT_W'(1);
                    store_value_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from next-state so they line up with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            num_q          <= '0;
            fail_q         <= '0;
            bits_q         <= '0;
            timer_q        <= '0;
            input_value_q  <= 1'b0;
            store_value_q  <= 1'b0;
            compare_q      <= 1'b0;
            input_reset_q  <= 1'b0;
            system_reset_q <= 1'b0;
            unlocked_q     <= 1'b0;
            locked_out_q   <= 1'b0;
            state_code_q   <= '0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            fail_q         <= fail_d;
            bits_q         <= bits_d;
            timer_q        <= timer_d;
            input_value_q  <= input_value_d;
            store_value_q  <= store_value_d;
            compare_q      <= compare_d;
            input_reset_q  <= input_reset_d;
            system_reset_q <= system_reset_d;
            unlocked_q     <= (state_d == S_UNLOCKED);
            locked_out_q   <= (state_d == S_LOCKOUT);
            state_code_q   <= 4'(state_d);
        end
    end

    assign bits         = bits_q;
    assign input_value  = input_value_q;
    assign store_value  = store_value_q;
    assign compare      = compare_q;
    assign input_reset  = input_reset_q;
    assign system_reset = system_reset_q;
    assign num_inputs   = num_q;
    assign fail_count   = fail_q;
    assign unlocked     = unlocked_q;
    assign locked_out   = locked_out_q;
    assign state_code   = state_code_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: expected pulses are queued at stimulus time and
// matched against DUT pulses on the falling edge; state/counters checked directly.
module tb_lock_sequencer;

    localparam int unsigned PASS_LEN       = 4;
    localparam int unsigned MAX_FAILS      = 3;
    localparam int unsigned LOCKOUT_CYCLES = 20;
    localparam int unsigned RESULT_TIMEOUT = 8;

    localparam logic [2:0] K_IN = 3'd1;
    localparam logic [2:0] K_ST = 3'd2;
    localparam logic [2:0] K_CMP = 3'd3;
    localparam logic [2:0] K_IR = 3'd4;
    localparam logic [2:0] K_SR = 3'd5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'h0;
    logic       submit = 1'b0;
    logic       program_req = 1'b0;
    logic       correct_password = 1'b0;
    logic       incorrect_password = 1'b0;
    logic [3:0] bits;
    logic       input_value, store_value, compare, input_reset, system_reset;
    logic [2:0] num_inputs, fail_count;
    logic       unlocked, locked_out;
    logic [3:0] state_code;

    int n_checks = 0;
    int n_errors = 0;
    logic [6:0] exp_q[$];

    lock_sequencer #(
        .PASS_LEN           (PASS_LEN),
        .MAX_FAILS          (MAX_FAILS),
        .LOCKOUT_CYCLES     (LOCKOUT_CYCLES),
        .RESULT_TIMEOUT     (RESULT_TIMEOUT)
`ifdef LOCKSEQ_AUTO_RELOCK_EN
        ,
        .AUTO_RELOCK_CYCLES (10)
`endif
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .digit_valid        (digit_valid),
        .digit              (digit),
        .submit             (submit),
        .program_req        (program_req),
        .correct_password   (correct_password),
        .incorrect_password (incorrect_password),
        .bits               (bits),
        .input_value        (input_value),
        .store_value        (store_value),
        .compare            (compare),
        .input_reset        (input_reset),
        .system_reset       (system_reset),
        .num_inputs         (num_inputs),
        .fail_count         (fail_count),
        .unlocked           (unlocked),
        .locked_out         (locked_out),
        .state_code         (state_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0 means the digit is expected to be dropped
    task automatic press(input logic [3:0] d, input logic [2:0] kind);
        digit       = d;
        digit_valid = 1'b1;
        if (kind != 3'd0) exp_q.push_back({kind, d});
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic push_ev(input logic [2:0] kind);
        exp_q.push_back({kind, 4'h0});
    endtask

    task automatic do_submit();
        submit = 1'b1;
        tick();
        submit = 1'b0;
    endtask

    task automatic enter_code();
        press(4'd1, K_IN);
        press(4'd2, K_IN);
        press(4'd3, K_IN);
        press(4'd4, K_IN);
        push_ev(K_CMP);
        do_submit();
    endtask

    task automatic answer(input logic c, input logic ic);
        tick();
        correct_password   = c;
        incorrect_password = ic;
        tick();
        correct_password   = 1'b0;
        incorrect_password = 1'b0;
    endtask

    // Pulse monitor: every strobe seen must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [4:0] p;
        logic [6:0] got;
        logic [6:0] exp;
        p = {system_reset, input_reset, compare, store_value, input_value};
        for (int k = 0; k < 5; k++) begin
            if (p[k]) begin
                got = {3'(k + 1), (k < 2) ? bits : 4'h0};
                if (exp_q.size() == 0) exp = 7'h7f;
                else exp = exp_q.pop_front();
                check("pulse", 32'(got), 32'(exp));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #2 reset_n = 1'b0;
        #10;
        check("rst_outputs", 32'({bits, input_value, store_value, compare, input_reset,
              system_reset, num_inputs, fail_count, unlocked, locked_out, state_code}), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("rst_state", 32'(state_code), 32'd0);

        // correct code unlocks
        press(4'd1, K_IN);
        check("entry_state", 32'(state_code), 32'd1);
        press(4'd2, K_IN);
        press(4'd3, K_IN);
        press(4'd4, K_IN);
        check("entry_num", 32'(num_inputs), 32'd4);
        push_ev(K_CMP);
        do_submit();
        check("wait_state", 32'(state_code), 32'd2);
        check("compare_hi", 32'(compare), 32'd1);
        answer(1'b1, 1'b0);
        check("unl_flag", 32'(unlocked), 32'd1);
        check("unl_state", 32'(state_code), 32'd3);
        check("unl_fail", 32'(fail_count), 32'd0);

        // submit beats program_req in UNLOCKED
        push_ev(K_IR);
        submit      = 1'b1;
        program_req = 1'b1;
        tick();
        submit      = 1'b0;
        program_req = 1'b0;
        check("relock_state", 32'(state_code), 32'd0);
        check("relock_unl", 32'(unlocked), 32'd0);
        check("relock_num", 32'(num_inputs), 32'd0);

        // short entry, submit with a simultaneous digit
        press(4'd5, K_IN);
        press(4'd6, K_IN);
        check("short_num", 32'(num_inputs), 32'd2);
        digit       = 4'd7;
        digit_valid = 1'b1;
        submit      = 1'b1;
        tick();
        digit_valid = 1'b0;
        submit      = 1'b0;
        check("short_fail_state", 32'(state_code), 32'd4);
        push_ev(K_IR);
        tick();
        check("short_fail_cnt", 32'(fail_count), 32'd1);
        check("short_num_clr", 32'(num_inputs), 32'd0);
        check("short_idle", 32'(state_code), 32'd0);

        // unlock again, then reprogram
        enter_code();
        answer(1'b1, 1'b0);
        check("unl2_fail", 32'(fail_count), 32'd0);
        check("unl2_state", 32'(state_code), 32'd3);
        push_ev(K_SR);
        program_req = 1'b1;
        tick();
        program_req = 1'b0;
        check("prog_state", 32'(state_code), 32'd6);
        check("prog_num", 32'(num_inputs), 32'd0);
        press(4'd9, K_ST);
        press(4'd8, K_ST);
        do_submit();
        check("prog_early_state", 32'(state_code), 32'd6);
        check("prog_early_num", 32'(num_inputs), 32'd2);
        press(4'd7, K_ST);
        press(4'd6, K_ST);
        press(4'd5, 3'd0);
        check("prog_full_num", 32'(num_inputs), 32'd4);
        push_ev(K_IR);
        do_submit();
        check("prog_commit_state", 32'(state_code), 32'd0);
        check("prog_commit_num", 32'(num_inputs), 32'd0);

        // checker never answers
        enter_code();
        n = 0;
        while (state_code != 4'd4 && n < 50) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(RESULT_TIMEOUT));
        push_ev(K_IR);
        tick();
        check("timeout_fail_cnt", 32'(fail_count), 32'd1);

        // both answers together count as incorrect
        enter_code();
        answer(1'b1, 1'b1);
        check("both_state", 32'(state_code), 32'd4);
        push_ev(K_IR);
        tick();
        check("both_fail_cnt", 32'(fail_count), 32'd2);

        // third failure enters lockout
        enter_code();
        answer(1'b0, 1'b1);
        check("third_fail_state", 32'(state_code), 32'd4);
        tick();
        check("lock_state", 32'(state_code), 32'd5);
        check("lock_flag", 32'(locked_out), 32'd1);
        check("lock_fail_cnt", 32'(fail_count), 32'd3);
        push_ev(K_IR);
        n = 0;
        while (locked_out && n < 100) begin
            digit       = 4'd7;
            digit_valid = 1'b1;
            tick();
            n++;
        end
        digit_valid = 1'b0;
        check("lock_cycles", 32'(n), 32'(LOCKOUT_CYCLES));
        check("post_lock_state", 32'(state_code), 32'd0);
        check("post_lock_fail", 32'(fail_count), 32'd0);
        check("post_lock_num", 32'(num_inputs), 32'd0);

        // asynchronous reset while waiting for a result
        enter_code();
        tick();
        check("pre_rst_state", 32'(state_code), 32'd2);
        reset_n = 1'b0;
        #2;
        check("midrst_outputs", 32'({bits, input_value, store_value, compare, input_reset,
              system_reset, num_inputs, fail_count, unlocked, locked_out, state_code}), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("midrst_idle", 32'(state_code), 32'd0);

        // unlocked hold time
        enter_code();
        answer(1'b1, 1'b0);
        check("hold_state", 32'(state_code), 32'd3);
`ifdef LOCKSEQ_AUTO_RELOCK_EN
        push_ev(K_IR);
`endif
        n = 0;
        while (unlocked && n < 40) begin
            tick();
            n++;
        end
`ifdef LOCKSEQ_AUTO_RELOCK_EN
        check("auto_relock_cycles", 32'(n), 32'd10);
        check("auto_relock_state", 32'(state_code), 32'd0);
`else
        check("hold_cycles", 32'(n), 32'd40);
        push_ev(K_IR);
        do_submit();
        check("hold_relock_state", 32'(state_code), 32'd0);
`endif

        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
